// File: rtl/pbus8_pkg.sv
// rtl/pbus8_pkg.sv - shared types, widths and parameter legality check for the pbus8 master
package pbus8_pkg;

   localparam int CNT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_TURN   = 3'd1,
      ST_SETUP  = 3'd2,
      ST_STROBE = 3'd3,
      ST_HOLD   = 3'd4
   } state_t;

   function automatic bit in_range(input int v);
      return (v >= 1) && (v <= 255);
   endfunction

   function automatic bit params_legal(input int wr_low, input int wr_high,
                                       input int rd_low, input int rd_high,
                                       input int turn);
      return in_range(wr_low) && in_range(wr_high) && in_range(rd_low) &&
             in_range(rd_high) && in_range(turn);
   endfunction

endpackage

// File: rtl/pbus8_timer.sv
// rtl/pbus8_timer.sv - loadable down-counter timing the TURN, STROBE and HOLD phases
module pbus8_timer
   import pbus8_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] value,
   output logic             done
);

   logic [CNT_W-1:0] count;

   // done marks the final cycle of a phase; the count parks at zero afterwards
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - CNT_W'(1);
      end
   end

   assign done = (count == CNT_W'(1));

endmodule

// File: rtl/pbus8_master.sv
// rtl/pbus8_master.sv - 8080-style 8-bit parallel bus master driven by a command stream
module pbus8_master
   import pbus8_pkg::*;
#(
   parameter int WR_LOW  = 2,
   parameter int WR_HIGH = 2,
   parameter int RD_LOW  = 4,
   parameter int RD_HIGH = 2,
   parameter int TURN    = 1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rw,
   input  logic       cmd_dc,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       cs_n,
   output logic       wr_n,
   output logic       rd_n,
   output logic       dc,
   output logic [7:0] bus_write,
   output logic       bus_oe,
   input  logic [7:0] bus_read
);

   if (!params_legal(WR_LOW, WR_HIGH, RD_LOW, RD_HIGH, TURN)) begin : g_bad_params
      $error("pbus8_master: every timing parameter must lie in 1..255");
   end

   state_t           state, next_state;
   logic             rw_q, dc_q, last_rd;
   logic [7:0]       data_q;
   logic             accept, load, tdone, capture, tx_next;
   logic [CNT_W-1:0] load_val;
   logic             cur_rw, cur_dc;
   logic [7:0]       cur_data;

   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign accept    = cmd_valid && cmd_ready;

   // Outputs are registered from next_state, so the command fields must be
   // visible combinationally on the accept edge.
   assign cur_rw   = accept ? cmd_rw   : rw_q;
   assign cur_dc   = accept ? cmd_dc   : dc_q;
   assign cur_data = accept ? cmd_data : data_q;

   assign tx_next = (next_state == ST_SETUP) || (next_state == ST_STROBE) ||
                    (next_state == ST_HOLD);
   assign capture = (state == ST_STROBE) && tdone && rw_q;

   always_comb begin
      next_state = state;
      load       = 1'b0;
      load_val   = '0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (!cmd_rw && last_rd) begin
                  next_state = ST_TURN;
                  load       = 1'b1;
                  load_val   = CNT_W'(TURN);
               end else begin
                  next_state = ST_SETUP;
               end
            end
         end
         ST_TURN: begin
            if (tdone) next_state = ST_SETUP;
         end
         ST_SETUP: begin
            next_state = ST_STROBE;
            load       = 1'b1;
            load_val   = rw_q ? CNT_W'(RD_LOW) : CNT_W'(WR_LOW);
         end
         ST_STROBE: begin
            if (tdone) begin
               next_state = ST_HOLD;
               load       = 1'b1;
               load_val   = rw_q ? CNT_W'(RD_HIGH) : CNT_W'(WR_HIGH);
            end
         end
         ST_HOLD: begin
            if (tdone) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   pbus8_timer u_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (load),
      .value   (load_val),
      .done    (tdone)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         rw_q      <= 1'b0;
         dc_q      <= 1'b0;
         data_q    <= 8'h00;
         last_rd   <= 1'b0;
         cs_n      <= 1'b1;
         wr_n      <= 1'b1;
         rd_n      <= 1'b1;
         dc        <= 1'b0;
         bus_oe    <= 1'b0;
         bus_write <= 8'h00;
         rsp_valid <= 1'b0;
         rsp_data  <= 8'h00;
      end else begin
         state <= next_state;
         if (accept) begin
            rw_q   <= cmd_rw;
            dc_q   <= cmd_dc;
            data_q <= cmd_data;
         end
         cs_n   <= !tx_next;
         wr_n   <= !((next_state == ST_STROBE) && !cur_rw);
         rd_n   <= !((next_state == ST_STROBE) && cur_rw);
         bus_oe <= tx_next && !cur_rw;
         if (next_state == ST_SETUP) begin
            dc <= cur_dc;
            if (!cur_rw) bus_write <= cur_data;
         end
         rsp_valid <= capture;
         if (capture) rsp_data <= bus_read;
         if ((state == ST_HOLD) && tdone) last_rd <= rw_q;
      end
   end

endmodule
